// File: rtl/apb_reg_slave.sv
// APB completer: bank of NUM_REGS byte-strobed 32-bit registers at BASE_ADDR.
// Latency: setup + WAIT_STATES + 1 access cycles (2 + WAIT_STATES total); outputs registered.
// Backpressure: pready held low for WAIT_STATES access cycles; psel drop aborts the transfer.
module apb_reg_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 0,
    parameter bit          PRIV_ONLY   = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    input  logic        pprot,
    input  logic [3:0]  pstrb,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam int          IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [31:0] WIN_BYTES = 32'(NUM_REGS * 4);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic             err_q, err_d;
    logic             wr_q, wr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      prdata_q, prdata_d;
    logic             pready_q, pready_d;
    logic             pslverr_q, pslverr_d;
    logic             commit;

    logic [31:0]      regs_q [NUM_REGS];

    // Address decode of the setup-phase request. The subtraction wraps for
    // addresses below the base, so the explicit below-base test is required.
    logic [31:0]      dec_off;
    logic             dec_err;
    logic [IDX_W-1:0] dec_idx;
    logic [31:0]      dec_rdata;

    assign dec_off   = paddr - BASE_ADDR;
    assign dec_err   = (paddr < BASE_ADDR)
                    || (dec_off >= WIN_BYTES)
                    || (paddr[1:0] != 2'b00)
                    || (PRIV_ONLY && !pprot);
    assign dec_idx   = dec_off[IDX_W+1:2];
    // Reads of an erroring or write access return zero so prdata never leaks data.
    assign dec_rdata = (!dec_err && !pwrite) ? regs_q[dec_idx] : 32'h0;

    // Next-state logic for the IDLE/ACCESS transfer sequencer and output registers.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        err_d     = err_q;
        wr_d      = wr_q;
        idx_d     = idx_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        commit    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = 32'h0;
                // Only a genuine setup cycle starts a transfer; a stray penable is ignored.
                if (psel && !penable) begin
                    state_d  = ST_ACCESS;
                    wait_d   = WAIT_LOAD;
                    err_d    = dec_err;
                    wr_d     = pwrite;
                    idx_d    = dec_idx;
                    prdata_d = dec_rdata;
                    // No wait states: completion is presented in the first access cycle.
                    if (WAIT_LOAD == 4'd0) begin
                        pready_d  = 1'b1;
                        pslverr_d = dec_err;
                    end
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    // Abort: drop the transfer without committing anything.
                    state_d   = ST_IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = 32'h0;
                end else if (penable && pready_q) begin
                    // Completion edge; writes land here so a following read sees them.
                    state_d   = ST_IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = 32'h0;
                    commit    = wr_q && !err_q;
                end else if (penable && (wait_q != 4'd0)) begin
                    wait_d = wait_q - 4'd1;
                    if (wait_q == 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            wait_q    <= 4'd0;
            err_q     <= 1'b0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            prdata_q  <= 32'h0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            wr_q      <= wr_d;
            idx_q     <= idx_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Register bank: byte-lane writes using data and strobes held at completion.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (commit) begin
            for (int l = 0; l < 4; l++) begin
                if (pstrb[l]) begin
                    regs_q[idx_q][8*l +: 8] <= pwdata[8*l +: 8];
                end
            end
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave across three parameterisations.
// Instance 0: defaults; instance 1: 3 wait states; instance 2: 2 wait states, privileged only.
// Driver pushes expected completions; a negedge monitor pops and compares them.
module tb_apb_reg_slave;

    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        int          k;
        bit          err;
        logic [31:0] rdata;
        int          setup;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        psel    [3];
    logic        penable [3];
    logic        pwrite  [3];
    logic        pprot   [3];
    logic [31:0] paddr   [3];
    logic [31:0] pwdata  [3];
    logic [3:0]  pstrb   [3];
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [2:0]  quiet_req = 3'b000;
    bit          done = 1'b0;
    exp_t        exp_q [$];
    logic [31:0] mdl [3][16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_reg_slave #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .pprot(pprot[0]), .pstrb(pstrb[0]),
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));

    apb_reg_slave #(.WAIT_STATES(3)) u_dut1 (
        .clk(clk), .rstn(rstn), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .pprot(pprot[1]), .pstrb(pstrb[1]),
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

    apb_reg_slave #(.WAIT_STATES(2), .PRIV_ONLY(1'b1)) u_dut2 (
        .clk(clk), .rstn(rstn), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
        .paddr(paddr[2]), .pwdata(pwdata[2]), .pprot(pprot[2]), .pstrb(pstrb[2]),
        .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]));

    function automatic int ws_of(input int k);
        case (k)
            1:       return 3;
            2:       return 2;
            default: return 0;
        endcase
    endfunction

    // Reference decode: window is [BASE, BASE+64), word aligned, instance 2 needs pprot.
    function automatic bit model_err(input int k, input logic [31:0] a, input bit prot);
        bit below, above, misal, priv;
        below = (a < BASE);
        above = (a >= BASE + 32'd64);
        misal = ((a % 4) != 0);
        priv  = (k == 2) && !prot;
        return below || above || misal || priv;
    endfunction

    task automatic push_exp(input int k, input bit err, input logic [31:0] rd);
        exp_t e;
        e.k     = k;
        e.err   = err;
        e.rdata = rd;
        e.setup = cyc + 1;
        exp_q.push_back(e);
    endtask

    // One transfer; entered just after a rising edge, leaves psel/penable high
    // just after the completion edge so a following call streams back-to-back.
    task automatic xfer(input int k, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input bit prot);
        bit          err;
        int          idx;
        int          n;
        logic [31:0] rd;
        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
        paddr[k] = a; pwdata[k] = d; pstrb[k] = s; pprot[k] = prot;
        err = model_err(k, a, prot);
        idx = int'(a[5:2]);
        rd  = (!wr && !err) ? mdl[k][idx] : 32'h0;
        push_exp(k, err, rd);
        if (wr && !err) begin
            for (int l = 0; l < 4; l++) begin
                if (s[l]) mdl[k][idx][8*l +: 8] = d[8*l +: 8];
            end
        end
        @(posedge clk); #1;
        penable[k] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pready[k] && n < 64);
        if (!pready[k]) begin
            psel[k] = 1'b0;
            penable[k] = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int k);
        psel[k] = 1'b0;
        penable[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    // Monitor: sole owner of the check counters.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (quiet_req[k]) begin
                checks++;
                if (pready[k] !== 1'b0 || pslverr[k] !== 1'b0 || prdata[k] !== 32'h0) begin
                    errors++;
                    $display("FAIL quiet k=%0d pready=%b pslverr=%b prdata=%h required 0/0/0",
                             k, pready[k], pslverr[k], prdata[k]);
                end
            end
            if (pready[k] === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].k != k) begin
                    errors++;
                    $display("FAIL unexpected_pready k=%0d cyc=%0d", k, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc - e.setup != ws_of(k)) begin
                        errors++;
                        $display("FAIL latency k=%0d got=%0d required=%0d", k, cyc - e.setup, ws_of(k));
                    end
                    checks++;
                    if (pslverr[k] !== e.err) begin
                        errors++;
                        $display("FAIL pslverr k=%0d got=%b required=%b", k, pslverr[k], e.err);
                    end
                    checks++;
                    if (prdata[k] !== e.rdata) begin
                        errors++;
                        $display("FAIL prdata k=%0d got=%h required=%h", k, prdata[k], e.rdata);
                    end
                end
            end else if (pslverr[k] === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL pslverr_without_pready k=%0d", k);
            end
        end
        if (exp_q.size() > 0 && (cyc - exp_q[0].setup) > ws_of(exp_q[0].k)) begin
            checks++;
            errors++;
            $display("FAIL pready_late k=%0d waited=%0d required=%0d",
                     exp_q[0].k, cyc - exp_q[0].setup, ws_of(exp_q[0].k));
            void'(exp_q.pop_front());
        end
        if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL pending_completions got=%0d required=0", exp_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_k;
        int k;
        int r;
        bit wr;
        bit prot;
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; pprot[i] = 1'b0;
            paddr[i] = 32'h0; pwdata[i] = 32'h0; pstrb[i] = 4'h0;
            for (int j = 0; j < 16; j++) mdl[i][j] = 32'h0;
        end
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 quiet_req = 3'b111;
        @(posedge clk); #1;
        quiet_req = 3'b000;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Streaming write then read-back of all registers.
        for (int i = 0; i < 16; i++) xfer(0, 1'b1, BASE + 32'(4*i), 32'h8000_0000 + 32'(4*i), 4'hF, 1'b0);
        for (int i = 0; i < 16; i++) xfer(0, 1'b0, BASE + 32'(4*i), 32'h0, 4'hF, 1'b0);

        // Error decodes, then confirm nothing changed.
        xfer(0, 1'b1, 32'h8000_0040, 32'hDEAD_BEEF, 4'hF, 1'b0);
        xfer(0, 1'b0, 32'h8000_0040, 32'h0, 4'hF, 1'b0);
        xfer(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'hF, 1'b0);
        xfer(0, 1'b1, 32'h7FFF_FFFC, 32'h1111_2222, 4'hF, 1'b0);
        xfer(0, 1'b0, 32'h8000_0002, 32'h0, 4'hF, 1'b0);
        xfer(0, 1'b1, 32'h8000_0002, 32'h3333_4444, 4'hF, 1'b0);
        for (int i = 0; i < 16; i++) xfer(0, 1'b0, BASE + 32'(4*i), 32'h0, 4'hF, 1'b0);

        // Byte strobes, including an empty strobe.
        xfer(0, 1'b1, BASE + 32'd20, 32'hFFFF_FFFF, 4'hF, 1'b0);
        xfer(0, 1'b1, BASE + 32'd20, 32'h1234_5678, 4'b0101, 1'b0);
        xfer(0, 1'b0, BASE + 32'd20, 32'h0, 4'hF, 1'b0);
        xfer(0, 1'b1, BASE + 32'd20, 32'h0BAD_0BAD, 4'b0000, 1'b0);
        xfer(0, 1'b0, BASE + 32'd20, 32'h0, 4'hF, 1'b0);
        idle(0);

        // Wait states on instance 1.
        xfer(1, 1'b0, BASE + 32'd8, 32'h0, 4'hF, 1'b0);
        idle(1);
        xfer(1, 1'b1, BASE + 32'd8, 32'hCAFE_F00D, 4'hF, 1'b0);
        xfer(1, 1'b0, BASE + 32'd8, 32'h0, 4'hF, 1'b0);
        idle(1);

        // penable without a setup cycle must be ignored.
        psel[1] = 1'b1; penable[1] = 1'b1; quiet_req[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1 quiet_req[1] = 1'b0;
        idle(1);

        // Privileged-only instance.
        xfer(2, 1'b1, BASE + 32'd28, 32'h1111_1111, 4'hF, 1'b0);
        xfer(2, 1'b0, BASE + 32'd28, 32'h0, 4'hF, 1'b0);
        xfer(2, 1'b0, BASE + 32'd28, 32'h0, 4'hF, 1'b1);
        xfer(2, 1'b1, BASE + 32'd28, 32'h1111_1111, 4'hF, 1'b1);
        xfer(2, 1'b0, BASE + 32'd28, 32'h0, 4'hF, 1'b1);
        idle(2);

        // Randomised traffic across all instances.
        last_k = -1;
        for (int t = 0; t < 300; t++) begin
            k = $urandom_range(0, 2);
            if (last_k >= 0 && (k != last_k || $urandom_range(0, 3) == 0)) idle(last_k);
            r = $urandom_range(0, 15);
            if (r == 0)      a = BASE + 32'd64 + 32'(4 * $urandom_range(0, 15));
            else if (r == 1) a = BASE - 32'd4 - 32'(4 * $urandom_range(0, 15));
            else if (r == 2) a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            else             a = BASE + 32'(4 * $urandom_range(0, 15));
            wr   = $urandom_range(0, 1) == 1;
            prot = (k == 2) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) == 1);
            xfer(k, wr, a, $urandom, 4'($urandom_range(0, 15)), prot);
            last_k = k;
        end
        if (last_k >= 0) idle(last_k);

        // Abort a write on instance 2 during its second wait cycle.
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; pprot[2] = 1'b1;
        paddr[2] = BASE + 32'd28; pwdata[2] = 32'hA5A5_A5A5; pstrb[2] = 4'hF;
        @(posedge clk); #1 penable[2] = 1'b1;
        @(posedge clk); #1 psel[2] = 1'b0; penable[2] = 1'b0;
        @(posedge clk); #1 quiet_req[2] = 1'b1;
        @(posedge clk); #1 quiet_req[2] = 1'b0;
        xfer(2, 1'b0, BASE + 32'd28, 32'h0, 4'hF, 1'b1);
        idle(2);

        // Reset asserted at the completion edge of a write on instance 0.
        push_exp(0, 1'b0, 32'h0);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; pprot[0] = 1'b0;
        paddr[0] = BASE + 32'd12; pwdata[0] = 32'hDEAD_BEEF; pstrb[0] = 4'hF;
        @(posedge clk); #1 penable[0] = 1'b1;
        rstn = 1'b0;
        @(posedge clk); #1;
        quiet_req = 3'b111;
        rstn = 1'b1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(posedge clk); #1 quiet_req = 3'b000;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 16; j++) mdl[i][j] = 32'h0;
        for (int i = 0; i < 16; i++) xfer(0, 1'b0, BASE + 32'(4*i), 32'h0, 4'hF, 1'b0);
        idle(0);
        xfer(1, 1'b0, BASE + 32'd8, 32'h0, 4'hF, 1'b0);
        idle(1);
        xfer(2, 1'b0, BASE + 32'd28, 32'h0, 4'hF, 1'b1);
        idle(2);

        repeat (3) @(posedge clk);
        #1 done = 1'b1;
        repeat (5) @(posedge clk);
    end

endmodule
